// File: rtl/combi_sweep_driver_pkg.sv
// Shared constants and helpers for the combinational self-test sweep blocks.
package combi_sweep_driver_pkg;

    typedef logic [1:0] sweep_state_t;

    localparam sweep_state_t ST_IDLE        = 2'd0;
    localparam sweep_state_t ST_SETTLE_WAIT = 2'd1;
    localparam sweep_state_t ST_CHECK       = 2'd2;
    localparam sweep_state_t ST_DONE        = 2'd3;

    // Settle counter width covers the full 1..255 settle range.
    localparam int SETTLE_CNT_W = 8;

    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
        return (val == max_val) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/combi_sweep_driver_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over inc.
// Width is limited to 32 bits by the shared increment helper.
module combi_sweep_driver_sat_counter
    import combi_sweep_driver_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    localparam logic [W-1:0] MAX_VAL = {W{1'b1}};

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = W'(sat_inc(32'(count_q), 32'(MAX_VAL)));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/combi_sweep_driver.sv
// Exhaustive stimulus sweep + response compare for combinational blocks.
// Build option: COMBI_SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
//   state          | meaning
//   ST_IDLE        | waiting for start after reset
//   ST_SETTLE_WAIT | stim applied, counting settle cycles
//   ST_CHECK       | compare dut vs ref, then advance stim or finish
//   ST_DONE        | results valid, start restarts the sweep
module combi_sweep_driver
    import combi_sweep_driver_pkg::*;
#(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 1,
    parameter int SETTLE    = 2,
    parameter int ERR_W     = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    output logic [IN_WIDTH-1:0]  stim_o,
    input  logic [OUT_WIDTH-1:0] dut_out_i,
    input  logic [OUT_WIDTH-1:0] ref_out_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic [ERR_W-1:0]     err_count_o,
    output logic [IN_WIDTH-1:0]  first_fail_o,
    output logic                 fail_seen_o
);

    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'(SETTLE - 1);

    sweep_state_t              state_q, state_d;
    logic [SETTLE_CNT_W-1:0]   cnt_q, cnt_d;
    logic [IN_WIDTH-1:0]       stim_q, stim_d;
    logic [IN_WIDTH-1:0]       first_fail_q, first_fail_d;
    logic                      fail_seen_q, fail_seen_d;
    logic                      err_clear;
    logic                      mismatch;

    assign mismatch = (state_q == ST_CHECK) && (dut_out_i != ref_out_i);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        stim_d       = stim_q;
        first_fail_d = first_fail_q;
        fail_seen_d  = fail_seen_q;
        err_clear    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    stim_d       = '0;
                    first_fail_d = '0;
                    fail_seen_d  = 1'b0;
                    cnt_d        = '0;
                    err_clear    = 1'b1;
                    state_d      = ST_SETTLE_WAIT;
                end
            end
            ST_SETTLE_WAIT: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_CHECK: begin
                if (mismatch && !fail_seen_q) begin
                    first_fail_d = stim_q;
                    fail_seen_d  = 1'b1;
                end
`ifdef COMBI_SWEEP_STOP_ON_FAIL_EN
                // Freeze stim on the failing vector so it can be probed.
                if (mismatch || (&stim_q)) begin
                    state_d = ST_DONE;
                end else begin
                    stim_d  = stim_q + 1'b1;
                    cnt_d   = '0;
                    state_d = ST_SETTLE_WAIT;
                end
`else
                if (&stim_q) begin
                    state_d = ST_DONE;
                end else begin
                    stim_d  = stim_q + 1'b1;
                    cnt_d   = '0;
                    state_d = ST_SETTLE_WAIT;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            stim_q       <= '0;
            first_fail_q <= '0;
            fail_seen_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            stim_q       <= stim_d;
            first_fail_q <= first_fail_d;
            fail_seen_q  <= fail_seen_d;
        end
    end

    combi_sweep_driver_sat_counter #(
        .W (ERR_W)
    ) u_err_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (err_clear),
        .inc_i   (mismatch),
        .count_o (err_count_o)
    );

    assign stim_o       = stim_q;
    assign busy_o       = (state_q == ST_SETTLE_WAIT) || (state_q == ST_CHECK);
    assign done_o       = (state_q == ST_DONE);
    assign pass_o       = done_o && (err_count_o == '0);
    assign first_fail_o = first_fail_q;
    assign fail_seen_o  = fail_seen_q;

endmodule

// File: tb/tb_combi_sweep_driver.sv
// Self-checking bench: 4-bit sweep of a 2+2-bit adder with injectable per-vector faults.
module tb_combi_sweep_driver;

    localparam int IN_W  = 4;
    localparam int OUT_W = 2;
    localparam int SET   = 2;
    localparam int EW    = 2;
    localparam int PER   = SET + 1;
    localparam int NV    = 1 << IN_W;
    localparam int EMAX  = (1 << EW) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [IN_W-1:0]  stim;
    logic [OUT_W-1:0] dut_out, ref_out;
    logic             busy, done, pass, fail_seen;
    logic [EW-1:0]    err_count;
    logic [IN_W-1:0]  first_fail;
    logic [31:0]      faults = 32'h0;
    logic [2:0]       sum;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Reference: {carry, sum msb} of a + b with {a, b} = stim; DUT = ref xor fault mask.
    assign sum     = {1'b0, stim[3:2]} + {1'b0, stim[1:0]};
    assign ref_out = sum[2:1];
    assign dut_out = ref_out ^ faults[2*stim +: 2];

    combi_sweep_driver #(
        .IN_WIDTH (IN_W),
        .OUT_WIDTH(OUT_W),
        .SETTLE   (SET),
        .ERR_W    (EW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .stim_o      (stim),
        .dut_out_i   (dut_out),
        .ref_out_i   (ref_out),
        .busy_o      (busy),
        .done_o      (done),
        .pass_o      (pass),
        .err_count_o (err_count),
        .first_fail_o(first_fail),
        .fail_seen_o (fail_seen)
    );

    typedef struct {
        string       name;
        logic [31:0] faults;
        int          err;
        int          ff;
        logic        pass;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int eff_err(input int err);
`ifdef COMBI_SWEEP_STOP_ON_FAIL_EN
        return (err > 0) ? 1 : 0;
`else
        return err;
`endif
    endfunction

    function automatic int eff_cycles(input int err, input int ff);
`ifdef COMBI_SWEEP_STOP_ON_FAIL_EN
        return (err > 0) ? (ff + 1) * PER : NV * PER;
`else
        return NV * PER;
`endif
    endfunction

    function automatic int eff_stim_end(input int err, input int ff);
`ifdef COMBI_SWEEP_STOP_ON_FAIL_EN
        return (err > 0) ? ff : NV - 1;
`else
        return NV - 1;
`endif
    endfunction

    // Starts a sweep from a negedge; restart_at >= 0 pulses start again mid-sweep.
    task automatic run_sweep(input string tag, input logic [31:0] f, input int e_err,
                             input int e_ff, input logic e_pass, input int restart_at);
        int k;
        int bad;
        int x_err;
        x_err  = eff_err(e_err);
        faults = f;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_clear_on_start"}, {28'h0, done, fail_seen, err_count != 0, first_fail != 0}, 32'h0);
        k   = 0;
        bad = 0;
        while (done !== 1'b1 && k < 200) begin
            start = (k == restart_at);
            if (stim !== IN_W'(k / PER) || busy !== 1'b1) bad++;
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        chk({tag, "_stim_busy_track"}, bad, 0);
        chk({tag, "_done_cycle"}, k, eff_cycles(e_err, e_ff));
        chk({tag, "_err_count"}, err_count, x_err);
        chk({tag, "_first_fail"}, first_fail, e_ff);
        chk({tag, "_fail_seen"}, fail_seen, (x_err > 0));
        chk({tag, "_pass"}, pass, e_pass);
        chk({tag, "_stim_end"}, stim, eff_stim_end(e_err, e_ff));
        chk({tag, "_busy_end"}, busy, 0);
    endtask

    vec_t tbl[6];

    initial begin
        tbl[0] = '{"clean",     32'h0000_0000, 0, 0, 1'b1};
        tbl[1] = '{"fault9",    32'h0004_0000, 1, 9, 1'b0};
        tbl[2] = '{"all_inv",   32'hFFFF_FFFF, 3, 0, 1'b0};
        tbl[3] = '{"fault3",    32'h0000_0080, 1, 3, 1'b0};
        tbl[4] = '{"fault5_15", 32'h4000_0400, 2, 5, 1'b0};
        tbl[5] = '{"fault024",  32'h0000_0111, 3, 0, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset_outputs", {stim, first_fail, err_count, busy, done, pass, fail_seen},
            32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_no_start", {28'h0, busy, done, pass, fail_seen}, 32'h0);

        for (int i = 0; i < 6; i++) begin
            run_sweep(tbl[i].name, tbl[i].faults, tbl[i].err, tbl[i].ff, tbl[i].pass, -1);
        end

        // Randomized fault masks against a vector-level model.
        for (int r = 0; r < 8; r++) begin
            logic [31:0] f;
            int cnt, ff;
            f   = $urandom() & $urandom() & $urandom();
            cnt = 0;
            ff  = 0;
            for (int v = NV - 1; v >= 0; v--) begin
                if (((f >> (2 * v)) & 32'h3) != 0) begin
                    cnt++;
                    ff = v;
                end
            end
            run_sweep($sformatf("rand%0d", r), f, (cnt > EMAX) ? EMAX : cnt, ff, (cnt == 0), -1);
        end

        // Start while busy is ignored; clean run must still finish at 48.
        run_sweep("restart_busy", 32'h0, 0, 0, 1'b1, 10);

        // Reset mid-sweep clears everything, then a clean sweep follows.
        faults = 32'h0000_0004;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("pre_rst_err", err_count, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_outputs", {stim, first_fail, err_count, busy, done, pass, fail_seen},
            32'h0);
        @(negedge clk);
        chk("post_rst_idle", busy, 0);
        run_sweep("after_rst", 32'h0, 0, 0, 1'b1, -1);

        // Restart from DONE after a failing run; clear checked inside run_sweep.
        run_sweep("fail_before_restart", 32'h0004_0000, 1, 9, 1'b0, -1);
        run_sweep("restart_from_done", 32'h0, 0, 0, 1'b1, -1);

        // rst and start together: rst wins.
        start = 1'b1;
        rst   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        chk("rst_beats_start", {28'h0, busy, done, pass, fail_seen}, 32'h0);
        @(negedge clk);
        chk("rst_beats_start_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
